// File: rtl/m_rep_pkg.sv
// Shared reply-path definitions used by the upload serializer and the reply FIFO.
package m_rep_pkg;

    localparam int FLIT_W        = 16;
    localparam int REP_FLITS_MAX = 9;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/m_rep_fifo_mem.sv
// Reply-flit storage: DEPTH x FLIT_W registers, one write port, one asynchronous read port.
module m_rep_fifo_mem
    import m_rep_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [FLIT_W-1:0] rdata
);

    flit_t mem [DEPTH];

    // Write the incoming flit into the addressed slot; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The head flit is read combinationally from the registered read pointer.
    assign rdata = mem[raddr];

endmodule

// File: rtl/m_rep_fifo.sv
// First-word-fall-through buffer between the reply upload serializer and the ring injection port.
module m_rep_fifo
    import m_rep_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] m_flit_in,
    input  logic              v_m_flit_in,
    output logic              rep_fifo_rdy,
    output logic [FLIT_W-1:0] flit_out,
    output logic              v_flit_out,
    input  logic              flit_out_ack,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;

    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    flit_t rd_data;

    // Flags come only from the registered count, so an ack in a full cycle
    // cannot open the door for a push in that same cycle.
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = v_m_flit_in && !full;
    assign pop   = flit_out_ack && !empty;

    m_rep_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata (m_flit_in),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    // Next-state computation for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CNT_W'(1);
        end
        if (v_m_flit_in && full) begin
            overflow_next = 1'b1;
        end
    end

    // State register; reset discards all buffered flits and clears the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign rep_fifo_rdy = !full;
    assign v_flit_out   = !empty;
    assign flit_out     = empty ? '0 : rd_data;
    assign fifo_count   = count_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_m_rep_fifo.sv
// Self-checking bench for m_rep_fifo against a queue-based reference model.
module tb_m_rep_fifo;
    import m_rep_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    flit_t       m_flit_in;
    logic        v_m_flit_in;
    logic        rep_fifo_rdy;
    flit_t       flit_out;
    logic        v_flit_out;
    logic        flit_out_ack;
    logic [ADDR_W:0] fifo_count;
    logic        overflow;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a plain queue of flits plus the sticky error bit.
    flit_t q_m[$];
    bit    ovf_m;

    m_rep_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_flit_in    (m_flit_in),
        .v_m_flit_in  (v_m_flit_in),
        .rep_fifo_rdy (rep_fifo_rdy),
        .flit_out     (flit_out),
        .v_flit_out   (v_flit_out),
        .flit_out_ack (flit_out_ack),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Expected {count, valid, head, ready, overflow} derived from the model queue.
    function automatic logic [23:0] model_vec();
        logic [4:0] c;
        flit_t      h;
        c = 5'(q_m.size());
        h = (q_m.size() == 0) ? 16'h0000 : q_m[0];
        return {c, q_m.size() != 0, h, q_m.size() != DEPTH, ovf_m};
    endfunction

    function automatic logic [23:0] dut_vec();
        return {fifo_count, v_flit_out, flit_out, rep_fifo_rdy, overflow};
    endfunction

    // Apply one clock of stimulus and advance the model by the FIFO rules.
    task automatic step(input logic v, input flit_t d, input logic a);
        bit was_full, was_empty;
        v_m_flit_in  = v;
        m_flit_in    = d;
        flit_out_ack = a;
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
        end else begin
            was_full  = (q_m.size() == DEPTH);
            was_empty = (q_m.size() == 0);
            if (v && was_full) ovf_m = 1'b1;
            if (a && !was_empty) void'(q_m.pop_front());
            if (v && !was_full) q_m.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        step(1'b0, 16'h0, 1'b0);
        vectors++;
        if (dut_vec() !== {5'd0, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", dut_vec(), {5'd0, 1'b0, 16'h0000, 1'b1, 1'b0});
        end
    endtask

    task automatic test_order();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, flit_t'(16'hA000 + i), 1'b0);
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL order_fill[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if (fifo_count !== 5'd9) begin
            miscompares++;
            $display("FAIL order_count: got %0d expected 9", fifo_count);
        end
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (v_flit_out !== 1'b1 || flit_out !== flit_t'(16'hA000 + i)) begin
                miscompares++;
                $display("FAIL order_head[%0d]: got v=%b %h expected v=1 %h", i, v_flit_out, flit_out, 16'hA000 + i);
            end
            step(1'b0, 16'h0, 1'b1);
        end
        vectors++;
        if (v_flit_out !== 1'b0 || flit_out !== 16'h0000 || fifo_count !== 5'd0) begin
            miscompares++;
            $display("FAIL order_drained: got v=%b flit=%h count=%0d expected v=0 flit=0000 count=0", v_flit_out, flit_out, fifo_count);
        end
        flit_out_ack = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, flit_t'($urandom_range(0, 16'hDEAC)), 1'b0);
        vectors++;
        if (rep_fifo_rdy !== 1'b0 || fifo_count !== 5'd16 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flags: got rdy=%b count=%0d ovf=%b expected rdy=0 count=16 ovf=0", rep_fifo_rdy, fifo_count, overflow);
        end
        step(1'b1, 16'hDEAD, 1'b0);
        vectors++;
        if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
            miscompares++;
            $display("FAIL overflow_set: got ovf=%b count=%0d expected ovf=1 count=16", overflow, fifo_count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (flit_out === 16'hDEAD || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL overflow_drain[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
            step(1'b0, 16'h0, 1'b1);
        end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < DEPTH; i++) step(1'b1, flit_t'($urandom), 1'b0);
        v_m_flit_in  = 1'b1;
        m_flit_in    = 16'hBEEF;
        flit_out_ack = 1'b1;
        #1;
        vectors++;
        if (rep_fifo_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ack_rdy_comb: got rdy=%b expected 0", rep_fifo_rdy);
        end
        step(1'b1, 16'hBEEF, 1'b1);
        vectors++;
        if (fifo_count !== 5'd15 || rep_fifo_rdy !== 1'b1 || dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d rdy=%b vec=%h expected count=15 rdy=1 vec=%h", fifo_count, rep_fifo_rdy, dut_vec(), model_vec());
        end
        for (int i = 0; i < 15; i++) begin
            vectors++;
            if (flit_out === 16'hBEEF || dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, dut_vec(), model_vec());
            end
            step(1'b0, 16'h0, 1'b1);
        end
    endtask

    task automatic test_streaming();
        flit_t d;
        for (int k = 0; k < 40; k++) begin
            d = flit_t'($urandom);
            step(1'b1, d, 1'b1);
            vectors++;
            if (fifo_count !== 5'd1 || v_flit_out !== 1'b1 || flit_out !== d) begin
                miscompares++;
                $display("FAIL stream[%0d]: got count=%0d v=%b flit=%h expected count=1 v=1 flit=%h", k, fifo_count, v_flit_out, flit_out, d);
            end
        end
        step(1'b0, 16'h0, 1'b1);
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("FAIL stream_end: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        int ack_pct;
        for (int k = 0; k < 400; k++) begin
            ack_pct = (k < 200) ? 30 : 70;
            step(1'($urandom_range(0, 99) < 60), flit_t'($urandom),
                 1'($urandom_range(0, 99) < ack_pct));
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
        for (int k = 0; k < DEPTH + 1; k++) step(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, flit_t'($urandom), 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 16'h0, 1'b1);
        vectors++;
        if (fifo_count !== 5'd5 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got count=%0d ovf=%b expected count=5 ovf=1", fifo_count, overflow);
        end
        rst = 1'b1;
        step(1'b1, 16'h1234, 1'b1);
        rst = 1'b0;
        vectors++;
        if (dut_vec() !== {5'd0, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got %h expected %h", dut_vec(), {5'd0, 1'b0, 16'h0000, 1'b1, 1'b0});
        end
        step(1'b1, 16'h5A5A, 1'b0);
        vectors++;
        if (fifo_count !== 5'd1 || flit_out !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL post_reset_push: got count=%0d flit=%h expected count=1 flit=5a5a", fifo_count, flit_out);
        end
    endtask

    initial begin
        rst          = 1'b1;
        v_m_flit_in  = 1'b0;
        m_flit_in    = '0;
        flit_out_ack = 1'b0;
        ovf_m        = 1'b0;
        test_reset();
        test_order();
        test_overflow();
        test_full_simul();
        test_streaming();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
